wb_port_arbiter: RTL and testbench

// - Shares the single register-file write port between two requesters:
//   - the W-stage writeback (ResultW/RdW/RegWriteW);
//   - a long-latency unit (e.g. mul/div) that returns results out of band.
// - W stage always has priority. Long results queue in a small FIFO and drain into idle W slots.
// - Exports a pending-Rd mask to the hazard unit, plus a stall request when the queue starves.

---
 rtl/wb_arb_pkg.sv | 9 +
 rtl/wb_fifo.sv | 58 +++++
 rtl/wb_port_arbiter.sv | 58 +++++
 tb/tb_wb_port_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared constants and FIFO entry type for the writeback port arbiter
package wb_arb_pkg;
  localparam int RD_W = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: long-result circular buffer with per-entry W-stage squash and pending-rd mask
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int WW = 32,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enq_i,
  input  logic [RD_W-1:0]     enq_rd_i,
  input  logic [WW-1:0]       enq_data_i,
  input  logic                pop_i,
  input  logic                sq_en_i,
  input  logic [RD_W-1:0]     sq_rd_i,
  output logic                full_o,
  output logic                empty_o,
  output wb_entry_t           head_o,
  output logic [WW-1:0]       head_data_o,
  output logic [NUM_REGS-1:0] mask_d_o
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [WW-1:0] data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0] cnt_q;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o = ent_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  // squash only sees pre-existing entries; the enqueue lands afterwards
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++)
      if (sq_en_i && ent_q[i].rd == sq_rd_i) ent_d[i].valid = 1'b0;
    if (pop_i) ent_d[rd_ptr_q].valid = 1'b0;
    if (enq_i) ent_d[wr_ptr_q] = '{valid: 1'b1, rd: enq_rd_i};
    mask_d_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_d[i].valid) mask_d_o[ent_d[i].rd] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ent_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      rd_ptr_q <= rd_ptr_q + AW'(pop_i);
      wr_ptr_q <= wr_ptr_q + AW'(enq_i);
      cnt_q <= cnt_q + (AW+1)'(enq_i) - (AW+1)'(pop_i);
    end
  always_ff @(posedge clk)
    if (enq_i) data_q[wr_ptr_q] <= enq_data_i;
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));
  a_no_enq_full: assert property (@(posedge clk) disable iff (!rst_n) !(enq_i && full_o));
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the W stage and queued long results
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int word_width = 32,
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteW,
  input  logic [RD_W-1:0]       RdW,
  input  logic [word_width-1:0] ResultW,
  input  logic                  LongValid,
  input  logic [RD_W-1:0]       LongRd,
  input  logic [word_width-1:0] LongResult,
  output logic                  LongReady,
  output logic                  RegFileWE,
  output logic [RD_W-1:0]       RegFileRd,
  output logic [word_width-1:0] RegFileWD,
  output logic [NUM_REGS-1:0]   PendingMask,
  output logic                  StallReq,
  output logic                  WbSrcLong
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic full, empty, w_w, head_v, pop, enq;
  wb_entry_t head;
  logic [word_width-1:0] head_data;
  logic [NUM_REGS-1:0] mask_d;
  logic [SW-1:0] starve_q, starve_d;
  wb_fifo #(.WW(word_width), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .enq_i(enq), .enq_rd_i(LongRd), .enq_data_i(LongResult),
    .pop_i(pop), .sq_en_i(w_w), .sq_rd_i(RdW), .full_o(full), .empty_o(empty),
    .head_o(head), .head_data_o(head_data), .mask_d_o(mask_d)
  );
  // W writes are gated by reset so the port reads idle the instant rst_n falls
  assign w_w = rst_n && RegWriteW && RdW != '0;
  assign head_v = !empty && head.valid;
  assign pop = !empty && !(head.valid && w_w);
  assign enq = LongValid && !full && LongRd != '0;
  assign LongReady = !full;
  assign RegFileWE = w_w || head_v;
  assign RegFileRd = w_w ? RdW : head_v ? head.rd : '0;
  assign RegFileWD = w_w ? ResultW : head_v ? head_data : '0;
  assign WbSrcLong = !w_w && head_v;
  assign StallReq = starve_q == SW'(STARVE_LIMIT);
  assign starve_d = (pop || empty) ? '0 :
                    (head_v && w_w && !StallReq) ? starve_q + SW'(1) : starve_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve_q <= '0;
      PendingMask <= '0;
    end else begin
      starve_q <= starve_d;
      PendingMask <= mask_d;
    end
  a_we_rd_nz: assert property (@(posedge clk) disable iff (!rst_n) RegFileWE |-> RegFileRd != '0);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed cycle vectors plus async-reset sequence for wb_port_arbiter
module tb_wb_port_arbiter;
  logic clk, rst_n, RegWriteW, LongValid, LongReady, RegFileWE, StallReq, WbSrcLong;
  logic [4:0] RdW, LongRd, RegFileRd;
  logic [31:0] ResultW, LongResult, RegFileWD, PendingMask;
  int checks = 0, errors = 0;
  typedef struct {
    logic rw; logic [4:0] rdw; logic [31:0] resw;
    logic lv; logic [4:0] lrd; logic [31:0] lres;
    logic [72:0] exp;
  } vec_t;
  vec_t vq[$];
  wb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .LongValid(LongValid), .LongRd(LongRd), .LongResult(LongResult), .LongReady(LongReady),
    .RegFileWE(RegFileWE), .RegFileRd(RegFileRd), .RegFileWD(RegFileWD),
    .PendingMask(PendingMask), .StallReq(StallReq), .WbSrcLong(WbSrcLong)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [72:0] o(input logic rdy, we, input logic [4:0] rd, input logic [31:0] wd,
                                    input logic src, stall, input logic [31:0] mask);
    return {rdy, we, rd, wd, src, stall, mask};
  endfunction
  task automatic add(input logic rw, input logic [4:0] rdw, input logic [31:0] resw, input logic lv,
                     input logic [4:0] lrd, input logic [31:0] lres, input logic [72:0] exp);
    vq.push_back('{rw, rdw, resw, lv, lrd, lres, exp});
  endtask
  task automatic drive(input logic rw, input logic [4:0] rdw, input logic [31:0] resw, input logic lv,
                       input logic [4:0] lrd, input logic [31:0] lres);
    RegWriteW = rw; RdW = rdw; ResultW = resw; LongValid = lv; LongRd = lrd; LongResult = lres;
  endtask
  task automatic chk(input string name, input logic [72:0] exp);
    logic [72:0] act;
    act = {LongReady, RegFileWE, RegFileRd, RegFileWD, WbSrcLong, StallReq, PendingMask};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got rdy=%b we=%b rd=%0d wd=%h src=%b stall=%b mask=%h want rdy=%b we=%b rd=%0d wd=%h src=%b stall=%b mask=%h",
               name, act[72], act[71], act[70:66], act[65:34], act[33], act[32], act[31:0],
               exp[72], exp[71], exp[70:66], exp[65:34], exp[33], exp[32], exp[31:0]);
    end
  endtask
  initial begin
    logic [72:0] idle;
    idle = o(1, 0, 0, 0, 0, 0, 0);
    // single long result to x5
    add(0, 0, 0, 1, 5, 32'hDEADBEEF, idle);
    add(0, 0, 0, 0, 0, 0, o(1, 1, 5, 32'hDEADBEEF, 1, 0, 32'h20));
    add(0, 0, 0, 0, 0, 0, idle);
    // W holds the port: queue x3, x4, starve, then drain
    add(1, 1, 32'hA1, 1, 3, 32'h33, o(1, 1, 1, 32'hA1, 0, 0, 0));
    add(1, 1, 32'hA1, 1, 4, 32'h44, o(1, 1, 1, 32'hA1, 0, 0, 32'h08));
    for (int i = 0; i < 3; i++) add(1, 1, 32'hA1, 0, 0, 0, o(0, 1, 1, 32'hA1, 0, 0, 32'h18));
    add(1, 1, 32'hA1, 0, 0, 0, o(0, 1, 1, 32'hA1, 0, 1, 32'h18));
    add(0, 0, 0, 0, 0, 0, o(0, 1, 3, 32'h33, 1, 1, 32'h18));
    add(0, 0, 0, 0, 0, 0, o(1, 1, 4, 32'h44, 1, 0, 32'h10));
    add(0, 0, 0, 0, 0, 0, idle);
    // WAW squash of queued x7
    add(0, 0, 0, 1, 7, 32'h77, idle);
    add(1, 7, 32'h11, 0, 0, 0, o(1, 1, 7, 32'h11, 0, 0, 32'h80));
    add(0, 0, 0, 0, 0, 0, idle);
    add(0, 0, 0, 0, 0, 0, idle);
    // offer to x0 is swallowed
    add(0, 0, 0, 1, 0, 32'h99, idle);
    add(0, 0, 0, 0, 0, 0, idle);
    add(0, 0, 0, 0, 0, 0, idle);
    // full FIFO: pop and offer in one cycle, offer taken next cycle
    add(1, 2, 32'h22, 1, 8, 32'h88, o(1, 1, 2, 32'h22, 0, 0, 0));
    add(1, 2, 32'h22, 1, 9, 32'h89, o(1, 1, 2, 32'h22, 0, 0, 32'h100));
    add(0, 0, 0, 1, 10, 32'h8A, o(0, 1, 8, 32'h88, 1, 0, 32'h300));
    add(0, 0, 0, 1, 10, 32'h8A, o(1, 1, 9, 32'h89, 1, 0, 32'h200));
    add(0, 0, 0, 0, 0, 0, o(1, 1, 10, 32'h8A, 1, 0, 32'h400));
    add(0, 0, 0, 0, 0, 0, idle);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 chk("reset_state", idle);
    rst_n = 1'b1;
    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].rw, vq[k].rdw, vq[k].resw, vq[k].lv, vq[k].lrd, vq[k].lres);
      #1 chk($sformatf("vec%0d", k), vq[k].exp);
    end
    // async reset with two entries queued and stall asserted
    @(negedge clk) drive(1, 1, 32'h1, 1, 12, 32'hC);
    @(negedge clk) drive(1, 1, 32'h1, 1, 13, 32'hD);
    @(negedge clk) drive(1, 1, 32'h1, 0, 0, 0);
    repeat (4) @(negedge clk);
    #1 chk("pre_reset", o(0, 1, 1, 32'h1, 0, 1, 32'h3000));
    #1 rst_n = 1'b0;
    #1 chk("async_reset", idle);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk($sformatf("post_reset%0d", i), idle);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
